// File: rtl/laser_shot_if.sv
// Bus between the laser block and its surroundings: frame/fire/hit controls,
// the ship's gun position, the current pixel, and the bolt state and colour going back.
interface laser_shot_if;
  logic       frameTick;
  logic       fire;
  logic [9:0] gunPosition;
  logic       hit;
  logic [9:0] hPos;
  logic [9:0] vPos;
  logic [9:0] laserX;
  logic [9:0] laserY;
  logic       active;
  logic [2:0] color;

  modport master (
    output frameTick, fire, gunPosition, hit, hPos, vPos,
    input  laserX, laserY, active, color
  );

  modport slave (
    input  frameTick, fire, gunPosition, hit, hPos, vPos,
    output laserX, laserY, active, color
  );
endinterface

// File: rtl/laser_shot.sv
// Player laser bolt: launch, per-frame flight, retire on hit/edge, cooldown, pixel colour.
// Optional macro LASER_AUTOFIRE_EN: IDLE launches on the fire level instead of its rising edge.
module laser_shot #(
  parameter int         SCREEN_HEIGHT   = 480,
  parameter int         V_OFFSET        = 10,
  parameter int         SHIP_HEIGHT     = 30,
  parameter int         SPEED           = 8,
  parameter int         LASER_WIDTH     = 4,
  parameter int         LASER_HEIGHT    = 12,
  parameter int         COOLDOWN_FRAMES = 15,
  parameter logic [2:0] LASER           = 3'd6,
  parameter logic [2:0] NONE            = 3'd7
) (
  input logic         clk,
  input logic         reset,
  laser_shot_if.slave bus
);

  localparam int          CNT_W    = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [9:0]  LAUNCH_Y = 10'(V_OFFSET + SHIP_HEIGHT);
  localparam logic [10:0] Y_LIMIT  = 11'(SCREEN_HEIGHT - V_OFFSET);
  localparam logic [10:0] HALF_W   = 11'(LASER_WIDTH / 2);
  localparam logic [10:0] LEN      = 11'(LASER_HEIGHT);

  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

  state_t           state, state_nxt;
  logic [9:0]       laser_x, laser_x_nxt;
  logic [9:0]       laser_y, laser_y_nxt;
  logic             active, active_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             fire_d;
  logic             armed;
  logic             launch;
  logic [10:0]      y_step;
  logic             on_bolt_p0;
  logic [2:0]       color_p1;

  // Left edge of the bolt, saturated at column 0 when the bolt hugs the left border.
  function automatic logic [10:0] clamp_left(input logic [9:0] x);
    logic [10:0] xe;
    xe = {1'b0, x};
    return (xe < HALF_W) ? 11'd0 : (xe - HALF_W);
  endfunction

  function automatic logic in_bolt(input logic [9:0] x, input logic [9:0] y,
                                   input logic [9:0] h, input logic [9:0] v);
    logic [10:0] he, ve, ye;
    he = {1'b0, h};
    ve = {1'b0, v};
    ye = {1'b0, y};
    return (he >= clamp_left(x)) && (he < ({1'b0, x} + HALF_W)) &&
           (ve >= ye) && (ve < (ye + LEN));
  endfunction

  // armed stays low after reset until fire has been seen released, so a button
  // held through reset cannot launch a bolt.
`ifdef LASER_AUTOFIRE_EN
  assign launch = armed & bus.fire;
`else
  assign launch = armed & bus.fire & ~fire_d;
`endif

  assign y_step     = {1'b0, laser_y} + 11'(SPEED);
  assign on_bolt_p0 = active && in_bolt(laser_x, laser_y, bus.hPos, bus.vPos);

  always_comb begin
    state_nxt   = state;
    laser_x_nxt = laser_x;
    laser_y_nxt = laser_y;
    active_nxt  = active;
    cnt_nxt     = cnt;
    unique case (state)
      IDLE: begin
        if (launch) begin
          state_nxt   = FLYING;
          laser_x_nxt = bus.gunPosition;
          laser_y_nxt = LAUNCH_Y;
          active_nxt  = 1'b1;
        end
      end
      FLYING: begin
        // A hit and an expiring frameTick collapse into one retire.
        if (bus.hit || (bus.frameTick && (y_step > Y_LIMIT))) begin
          state_nxt  = COOLDOWN;
          active_nxt = 1'b0;
          cnt_nxt    = CNT_W'(COOLDOWN_FRAMES);
        end else if (bus.frameTick) begin
          laser_y_nxt = y_step[9:0];
        end
      end
      COOLDOWN: begin
        if (bus.frameTick) begin
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> p1: state, bolt registers and registered pixel colour
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      laser_x  <= '0;
      laser_y  <= '0;
      active   <= 1'b0;
      cnt      <= '0;
      fire_d   <= 1'b0;
      armed    <= 1'b0;
      color_p1 <= NONE;
    end else begin
      state    <= state_nxt;
      laser_x  <= laser_x_nxt;
      laser_y  <= laser_y_nxt;
      active   <= active_nxt;
      cnt      <= cnt_nxt;
      fire_d   <= bus.fire;
      armed    <= armed | ~bus.fire;
      color_p1 <= on_bolt_p0 ? LASER : NONE;
    end
  end

  assign bus.laserX = laser_x;
  assign bus.laserY = laser_y;
  assign bus.active = active;
  assign bus.color  = color_p1;

endmodule

// File: tb/tb_laser_shot.sv
// Directed plus randomized bench for laser_shot against a frame-level behavioural model.
module tb_laser_shot;
`ifdef LASER_AUTOFIRE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  laser_shot_if bus();

  laser_shot dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 = waiting, 1 = bolt in flight, 2 = recharging.
  int m_mode, m_x, m_y, m_act, m_cnt, m_col, m_prev, m_armed;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_x = 0; m_y = 0; m_act = 0; m_cnt = 0;
    m_col = 7; m_prev = 0; m_armed = 0;
  endtask

  task automatic model_clock();
    int h, v, left, col_n;
    bit f, go;
    h = int'(bus.hPos);
    v = int'(bus.vPos);
    f = bus.fire;
    left = (m_x < 2) ? 0 : m_x - 2;
    col_n = (m_act != 0 && h >= left && h < m_x + 2 && v >= m_y && v < m_y + 12) ? 6 : 7;
    go = AUTO ? (m_armed != 0 && f) : (m_armed != 0 && f && m_prev == 0);
    if (!f) m_armed = 1;
    m_prev = f;
    case (m_mode)
      0: if (go) begin
           m_mode = 1; m_x = int'(bus.gunPosition); m_y = 40; m_act = 1;
         end
      1: if (bus.hit || (bus.frameTick && m_y + 8 > 470)) begin
           m_mode = 2; m_act = 0; m_cnt = 15;
         end else if (bus.frameTick) begin
           m_y = m_y + 8;
         end
      default: if (bus.frameTick) begin
           if (m_cnt == 0) m_mode = 0;
           else m_cnt = m_cnt - 1;
         end
    endcase
    m_col = col_n;
  endtask

  task automatic check_model();
    chk("model_laserX", int'(bus.laserX), m_x);
    chk("model_laserY", int'(bus.laserY), m_y);
    chk("model_active", int'(bus.active), m_act);
    chk("model_color",  int'(bus.color),  m_col);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) model_clock();
    else model_reset();
    #1;
    check_model();
  endtask

  task automatic frame();
    bus.frameTick = 1'b1; cyc();
    bus.frameTick = 1'b0; cyc();
  endtask

  task automatic press();
    bus.fire = 1'b1; cyc();
    bus.fire = 1'b0; cyc();
  endtask

  int pts_h[5] = '{318, 321, 322, 317, 320};
  int pts_v[5] = '{40, 51, 40, 40, 52};
  int pts_c[5] = '{6, 6, 7, 7, 7};

  initial begin
    bus.frameTick = 1'b0; bus.fire = 1'b1; bus.gunPosition = '0;
    bus.hit = 1'b0; bus.hPos = '0; bus.vPos = '0;
    model_reset();

    // Reset held with fire pressed
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_active", int'(bus.active), 0);
      chk("rst_color",  int'(bus.color),  7);
      chk("rst_laserX", int'(bus.laserX), 0);
      chk("rst_laserY", int'(bus.laserY), 0);
    end

    // Release with fire still held: no launch
    @(negedge clk); reset = 1'b1;
    repeat (4) cyc();
    chk("held_no_launch", int'(bus.active), 0);

    // Launch at gunPosition 320
    bus.fire = 1'b0; cyc();
    bus.gunPosition = 10'd320; bus.fire = 1'b1; cyc();
    chk("launch_active", int'(bus.active), 1);
    chk("launch_x", int'(bus.laserX), 320);
    chk("launch_y", int'(bus.laserY), 40);
    bus.fire = 1'b0; bus.gunPosition = 10'd500; cyc(); cyc();
    chk("x_latched", int'(bus.laserX), 320);

    // Colour probes around the fresh bolt
    for (int i = 0; i < 5; i++) begin
      bus.hPos = 10'(pts_h[i]); bus.vPos = 10'(pts_v[i]);
      cyc();
      chk($sformatf("color_%0d_%0d", pts_h[i], pts_v[i]), int'(bus.color), pts_c[i]);
    end
    bus.hPos = '0; bus.vPos = '0;

    // Second fire during flight ignored
    press();
    chk("refire_x", int'(bus.laserX), 320);
    chk("refire_y", int'(bus.laserY), 40);

    // Flight to the screen edge, then cooldown
    repeat (53) frame();
    chk("y_after_53", int'(bus.laserY), 464);
    chk("act_after_53", int'(bus.active), 1);
    frame();
    chk("act_after_54", int'(bus.active), 0);
    chk("y_hold_54", int'(bus.laserY), 464);
    for (int i = 0; i < 15; i++) begin
      frame(); press();
      chk($sformatf("cool_block_%0d", i), int'(bus.active), 0);
    end
    frame(); press();
    chk("relaunch_active", int'(bus.active), 1);
    chk("relaunch_y", int'(bus.laserY), 40);

    // Hit coinciding with the expiring frameTick
    repeat (53) frame();
    bus.frameTick = 1'b1; bus.hit = 1'b1; cyc();
    bus.frameTick = 1'b0; bus.hit = 1'b0; cyc();
    chk("dual_act", int'(bus.active), 0);
    chk("dual_y", int'(bus.laserY), 464);
    for (int i = 0; i < 15; i++) begin
      frame(); press();
      chk($sformatf("dual_block_%0d", i), int'(bus.active), 0);
    end
    frame(); press();
    chk("dual_relaunch", int'(bus.active), 1);

    // Hit mid-flight
    repeat (5) frame();
    chk("mid_y", int'(bus.laserY), 80);
    bus.hit = 1'b1; cyc(); bus.hit = 1'b0;
    chk("hit_act", int'(bus.active), 0);
    chk("hit_y", int'(bus.laserY), 80);
    repeat (16) frame();

    // Asynchronous reset mid-flight, fire held across release
    press();
    chk("pre_reset_act", int'(bus.active), 1);
    bus.fire = 1'b1;
    #2 reset = 1'b0;
    #1 model_reset();
    chk("async_act", int'(bus.active), 0);
    chk("async_x", int'(bus.laserX), 0);
    chk("async_y", int'(bus.laserY), 0);
    chk("async_color", int'(bus.color), 7);
    cyc();
    @(negedge clk); reset = 1'b1;
    repeat (3) cyc();
    chk("post_reset_no_launch", int'(bus.active), 0);
    bus.fire = 1'b0; cyc();

`ifdef LASER_AUTOFIRE_EN
    bus.fire = 1'b1; cyc();
    chk("auto_first", int'(bus.active), 1);
    for (int r = 0; r < 2; r++) begin
      repeat (54) frame();
      chk($sformatf("auto_retire_%0d", r), int'(bus.active), 0);
      repeat (16) frame();
      chk($sformatf("auto_relaunch_%0d", r), int'(bus.active), 1);
      chk($sformatf("auto_relaunch_y_%0d", r), int'(bus.laserY), 40);
    end
    bus.fire = 1'b0; cyc();
    repeat (70) frame();
`endif

    // Randomized traffic with probes steered around the bolt
    repeat (3000) begin
      bus.frameTick = ($urandom_range(0, 3) == 0);
      bus.hit = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 5) == 0) bus.fire = ~bus.fire;
      bus.gunPosition = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 3))
                                                    : 10'($urandom_range(0, 639));
      bus.hPos = 10'(m_x + int'($urandom_range(0, 7)) - 4);
      bus.vPos = 10'(m_y + int'($urandom_range(0, 17)) - 3);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/laser_shot.md
Name: laser_shot

Overview:
Fires and tracks the player's single laser bolt. It launches from the ship's current gunPosition and advances one step per video frame toward the alien field. It retires on a hit or at the screen edge, then enforces a cooldown before the next shot. It also returns the per-pixel LASER colour to the pixel mixer, alongside the ship block's colour.

Parameters:
SCREEN_HEIGHT, 480, visible lines
V_OFFSET, 10, top/bottom margin in lines
SHIP_HEIGHT, 30, ship height; the laser launches at vPos = V_OFFSET+SHIP_HEIGHT
SPEED, 8, lines advanced per frameTick
LASER_WIDTH, 4, bolt width in pixels, centred on laserX
LASER_HEIGHT, 12, bolt length in lines
COOLDOWN_FRAMES, 15, frames after retire before re-arm
LASER, 6, colour code for a laser pixel
NONE, 7, colour code for "not my pixel"

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
frameTick  in  1  one-cycle pulse per frame (start of vertical blank)
fire  in  1  fire button, already synchronous to clk, level
gunPosition  in  10  ship centre x, from the ship block
hit  in  1  one-cycle pulse from alien collision logic
hPos  in  10  current pixel x
vPos  in  10  current pixel y
laserX  out  10  bolt centre x
laserY  out  10  bolt leading-edge y
active  out  1  bolt in flight
color  out  3  LASER or NONE, registered

Behaviour:
- Reset (reset=0, async) drives the following:
  - state=IDLE, laserX=0, laserY=0, active=0, color=NONE
  - cooldown counter=0, fire edge register=0
- Fire edge: fireRise = fire & ~fire_d, where fire_d is registered each clk. A held button produces one shot only.
- IDLE:
  - On fireRise: go to FLYING the next cycle.
  - Latch laserX=gunPosition and laserY=V_OFFSET+SHIP_HEIGHT (40). Set active=1.
  - A frameTick in the same cycle does not move the bolt.
- FLYING:
  - fireRise is ignored; only one bolt exists.
  - gunPosition changes after launch do not move laserX.
  - hit=1: go to COOLDOWN the next cycle, active=0.
  - frameTick with laserY+SPEED > SCREEN_HEIGHT-V_OFFSET (470): go to COOLDOWN, active=0, laserY holds.
  - Otherwise frameTick: laserY <= laserY+SPEED. Compute the sum 11 bits wide so it cannot wrap.
  - hit and an expiring frameTick together: one COOLDOWN entry, no double count.
- COOLDOWN:
  - On entry, load counter=COOLDOWN_FRAMES.
  - Each frameTick decrements it. Leave for IDLE on the frameTick that finds counter==0.
  - COOLDOWN_FRAMES=0: IDLE at the first frameTick.
  - fireRise and hit are ignored.
- Colour, evaluated every clk in all states, one-cycle latency:
  - color=LASER when all of the following hold: active=1, laserX-LASER_WIDTH/2 <= hPos < laserX+LASER_WIDTH/2, and laserY <= vPos < laserY+LASER_HEIGHT.
  - Otherwise color=NONE.
  - Compare in 11-bit signed-safe arithmetic; laserX < LASER_WIDTH/2 clamps the left bound to 0.
- Reset mid-flight: immediate return to IDLE, bolt erased. The next shot needs a new fireRise after reset release.

Optional Feature:
Macro LASER_AUTOFIRE_EN.
- Defined: in IDLE the launch condition is the fire level, not fireRise. A held button re-fires automatically each time cooldown ends.
- Undefined: edge-only firing as above.
- All other behaviour is identical.

Test Plan:
- Reset low with fire=1 -> active=0, color=NONE, laserX=laserY=0. Release reset with fire still high -> no launch until fire goes 0 then 1.
- gunPosition=320, fire pulse -> next cycle active=1, laserX=320, laserY=40. Then gunPosition=500 -> laserX stays 320.
- Launched bolt, 53 frameTicks -> laserY=464. 54th frameTick -> active=0, COOLDOWN. 15 further frameTicks keep IDLE blocked; a fireRise after the 16th frameTick launches.
- Bolt at laserX=320, laserY=40 -> color=LASER one clk after (hPos=318,vPos=40) and (321,51). color=NONE for (322,40), (317,40) and (320,52).
- hit pulse on the same cycle as an expiring frameTick -> single COOLDOWN entry. Counter=15. fireRise during COOLDOWN ignored.
- LASER_AUTOFIRE_EN defined, fire held high -> relaunch at laserY=40 on the cycle after cooldown ends, repeatedly.
